// File: rtl/cp0_if.sv
// MEM/WB-side bundle for the CP0 register file: MTC0 writes, MFC0 reads,
// committed exception/ERET, and the status/cause/epc/badvaddr feedback to MEM.
interface cp0_if;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [2:0]  cp0_wsel;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [2:0]  cp0_rsel;
    logic [31:0] cp0_rdata;
    logic [4:0]  excepttype;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic [31:0] exc_badvaddr;
    logic [4:0]  hw_int;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;
    logic [31:0] cp0_badvaddr;
    logic        timer_int;

    modport master (
        output cp0_we, cp0_waddr, cp0_wsel, cp0_wdata, cp0_raddr, cp0_rsel,
               excepttype, exc_pc, exc_bd, exc_badvaddr, hw_int,
        input  cp0_rdata, cp0_status, cp0_cause, cp0_epc, cp0_badvaddr, timer_int
    );

    modport slave (
        input  cp0_we, cp0_waddr, cp0_wsel, cp0_wdata, cp0_raddr, cp0_rsel,
               excepttype, exc_pc, exc_bd, exc_badvaddr, hw_int,
        output cp0_rdata, cp0_status, cp0_cause, cp0_epc, cp0_badvaddr, timer_int
    );
endinterface

// File: rtl/cp0_reg.sv
// MIPS CP0 registers (BadVAddr/Count/Compare/Status/Cause/EPC); writes land next edge, reads are
// combinational with no bypass, never stalls. Count/Compare/timer exist only with CP0_TIMER_EN.
module cp0_reg #(
    parameter bit          COUNT_HALF_RATE = 1'b1,
    parameter logic [31:0] RESET_STATUS    = 32'h0040_0000
) (
    input  logic clk,
    input  logic rst,
    cp0_if.slave bus
);
    localparam logic [4:0] EXC_INT  = 5'h01;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;
    localparam logic [4:0] EXC_ERET = 5'h0e;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    logic [31:0] status, cause, epc, badvaddr;
    logic [31:0] status_n, cause_n, epc_n, badvaddr_n;
    logic [4:0]  exc_code;
    logic        ti_n;

    wire wr       = bus.cp0_we && (bus.cp0_wsel == 3'd0);
    wire exc_take = (bus.excepttype != 5'd0) && (bus.excepttype != EXC_ERET);
    wire eret     = (bus.excepttype == EXC_ERET);
    wire exl      = status[1];

    always_comb begin
        case (bus.excepttype)
            EXC_INT:  exc_code = 5'd0;
            EXC_ADEL: exc_code = 5'd4;
            EXC_ADES: exc_code = 5'd5;
            EXC_SYS:  exc_code = 5'd8;
            EXC_BP:   exc_code = 5'd9;
            EXC_RI:   exc_code = 5'd10;
            EXC_OV:   exc_code = 5'd12;
            default:  exc_code = bus.excepttype;
        endcase
    end

`ifdef CP0_TIMER_EN
    logic [31:0] count, compare;
    logic        tog;

    wire wr_count   = wr && (bus.cp0_waddr == REG_COUNT);
    wire wr_compare = wr && (bus.cp0_waddr == REG_COMPARE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= 32'd0;
            compare <= 32'd0;
            tog     <= 1'b0;
        end else begin
            if (wr_count) begin
                count <= bus.cp0_wdata;
                tog   <= 1'b0;
            end else begin
                tog <= COUNT_HALF_RATE ? ~tog : 1'b0;
                if (!COUNT_HALF_RATE || tog)
                    count <= count + 32'd1;
            end
            if (wr_compare)
                compare <= bus.cp0_wdata;
        end
    end

    // TI is sticky; a Compare write clears it even if the match fires on the same edge
    assign ti_n = !wr_compare && (cause[30] || ((count == compare) && (compare != 32'd0)));
`else
    wire unused_half_rate = COUNT_HALF_RATE;
    assign ti_n = 1'b0;
`endif

    // Exception/ERET updates are applied after the MTC0 write so they win on shared fields
    always_comb begin
        status_n = status;
        if (wr && bus.cp0_waddr == REG_STATUS)
            status_n = (status & ~STATUS_WMASK) | (bus.cp0_wdata & STATUS_WMASK);
        if (exc_take)
            status_n[1] = 1'b1;
        else if (eret)
            status_n[1] = 1'b0;

        cause_n        = cause;
        cause_n[14:10] = bus.hw_int;
        if (wr && bus.cp0_waddr == REG_CAUSE)
            cause_n[9:8] = bus.cp0_wdata[9:8];
        if (exc_take) begin
            if (!exl)
                cause_n[31] = bus.exc_bd;
            cause_n[6:2] = exc_code;
        end
        cause_n[30] = ti_n;

        epc_n = epc;
        if (wr && bus.cp0_waddr == REG_EPC)
            epc_n = bus.cp0_wdata;
        if (exc_take && !exl)
            epc_n = bus.exc_bd ? bus.exc_pc - 32'd4 : bus.exc_pc;

        badvaddr_n = badvaddr;
        if (bus.excepttype == EXC_ADEL || bus.excepttype == EXC_ADES)
            badvaddr_n = bus.exc_badvaddr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status   <= RESET_STATUS;
            cause    <= 32'd0;
            epc      <= 32'd0;
            badvaddr <= 32'd0;
        end else begin
            status   <= status_n;
            cause    <= cause_n;
            epc      <= epc_n;
            badvaddr <= badvaddr_n;
        end
    end

    always_comb begin
        bus.cp0_rdata = 32'd0;
        if (bus.cp0_rsel == 3'd0) begin
            case (bus.cp0_raddr)
                REG_BADVADDR: bus.cp0_rdata = badvaddr;
`ifdef CP0_TIMER_EN
                REG_COUNT:    bus.cp0_rdata = count;
                REG_COMPARE:  bus.cp0_rdata = compare;
`endif
                REG_STATUS:   bus.cp0_rdata = status;
                REG_CAUSE:    bus.cp0_rdata = cause;
                REG_EPC:      bus.cp0_rdata = epc;
                default:      bus.cp0_rdata = 32'd0;
            endcase
        end
    end

    assign bus.cp0_status   = status;
    assign bus.cp0_cause    = cause;
    assign bus.cp0_epc      = epc;
    assign bus.cp0_badvaddr = badvaddr;
    assign bus.timer_int    = cause[30];
endmodule

// File: tb/tb_cp0_reg.sv
// Directed bench for cp0_reg: reset, exception entry/nesting/ERET, MTC0 masks and overlap,
// unmapped accesses, and (with CP0_TIMER_EN) Count/Compare timer behaviour.
module tb_cp0_reg;
    localparam logic [4:0] EXC_INT  = 5'h01;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_ERET = 5'h0e;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    cp0_if bus ();
    cp0_reg #(.COUNT_HALF_RATE(1'b1), .RESET_STATUS(32'h0040_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef CP0_TIMER_EN
    cp0_if bus2 ();
    cp0_reg #(.COUNT_HALF_RATE(1'b0), .RESET_STATUS(32'h0040_0000)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.cp0_we       = 1'b0;
        bus.cp0_waddr    = 5'd0;
        bus.cp0_wsel     = 3'd0;
        bus.cp0_wdata    = 32'd0;
        bus.excepttype   = 5'd0;
        bus.exc_pc       = 32'd0;
        bus.exc_bd       = 1'b0;
        bus.exc_badvaddr = 32'd0;
`ifdef CP0_TIMER_EN
        bus2.cp0_we       = 1'b0;
        bus2.cp0_waddr    = 5'd0;
        bus2.cp0_wsel     = 3'd0;
        bus2.cp0_wdata    = 32'd0;
        bus2.excepttype   = 5'd0;
        bus2.exc_pc       = 32'd0;
        bus2.exc_bd       = 1'b0;
        bus2.exc_badvaddr = 32'd0;
        bus2.hw_int       = 5'd0;
        bus2.cp0_raddr    = 5'd9;
        bus2.cp0_rsel     = 3'd0;
`endif
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        bus.cp0_we    = 1'b1;
        bus.cp0_waddr = addr;
        bus.cp0_wsel  = 3'd0;
        bus.cp0_wdata = data;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        bus.hw_int    = 5'd0;
        bus.cp0_raddr = 5'd12;
        bus.cp0_rsel  = 3'd0;
        rst = 1'b1;
        tick();
        tick();
        nvec++; if (bus.cp0_status !== 32'h0040_0000) begin nerr++; $display("FAIL reset_status got %h exp %h", bus.cp0_status, 32'h0040_0000); end
        nvec++; if (bus.cp0_cause !== 32'd0) begin nerr++; $display("FAIL reset_cause got %h exp 0", bus.cp0_cause); end
        nvec++; if (bus.cp0_epc !== 32'd0) begin nerr++; $display("FAIL reset_epc got %h exp 0", bus.cp0_epc); end
        nvec++; if (bus.cp0_badvaddr !== 32'd0) begin nerr++; $display("FAIL reset_badvaddr got %h exp 0", bus.cp0_badvaddr); end
        nvec++; if (bus.timer_int !== 1'b0) begin nerr++; $display("FAIL reset_timer_int got %b exp 0", bus.timer_int); end
        nvec++; if (bus.cp0_rdata !== 32'h0040_0000) begin nerr++; $display("FAIL reset_rd_status got %h exp %h", bus.cp0_rdata, 32'h0040_0000); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_masks();
        mtc0(5'd12, 32'hFFFF_FFFF);
        nvec++; if (bus.cp0_status !== 32'h0040_FF03) begin nerr++; $display("FAIL status_mask_ones got %h exp %h", bus.cp0_status, 32'h0040_FF03); end
        mtc0(5'd12, 32'h0000_0000);
        nvec++; if (bus.cp0_status !== 32'h0040_0000) begin nerr++; $display("FAIL status_mask_zero got %h exp %h", bus.cp0_status, 32'h0040_0000); end
        bus.hw_int = 5'b10101;
        tick();
        nvec++; if (bus.cp0_cause !== 32'h0000_5400) begin nerr++; $display("FAIL cause_hw_int got %h exp %h", bus.cp0_cause, 32'h0000_5400); end
        mtc0(5'd13, 32'hFFFF_FFFF);
        bus.cp0_raddr = 5'd13;
        #1;
        nvec++; if (bus.cp0_rdata !== 32'h0000_5700) begin nerr++; $display("FAIL cause_ip_write got %h exp %h", bus.cp0_rdata, 32'h0000_5700); end
        mtc0(5'd13, 32'h0000_0000);
        bus.hw_int = 5'd0;
        tick();
        nvec++; if (bus.cp0_cause !== 32'd0) begin nerr++; $display("FAIL cause_clear got %h exp 0", bus.cp0_cause); end
    endtask

    task automatic test_unmapped();
        mtc0(5'd14, 32'h1234_5678);
        bus.cp0_we    = 1'b1;
        bus.cp0_waddr = 5'd14;
        bus.cp0_wsel  = 3'd1;
        bus.cp0_wdata = 32'hDEAD_BEEF;
        tick();
        idle();
        nvec++; if (bus.cp0_epc !== 32'h1234_5678) begin nerr++; $display("FAIL epc_sel1_write got %h exp %h", bus.cp0_epc, 32'h1234_5678); end
        mtc0(5'd8, 32'hDEAD_BEEF);
        nvec++; if (bus.cp0_badvaddr !== 32'd0) begin nerr++; $display("FAIL badvaddr_ro got %h exp 0", bus.cp0_badvaddr); end
        bus.cp0_raddr = 5'd14;
        bus.cp0_rsel  = 3'd1;
        #1;
        nvec++; if (bus.cp0_rdata !== 32'd0) begin nerr++; $display("FAIL read_sel1 got %h exp 0", bus.cp0_rdata); end
        bus.cp0_raddr = 5'd3;
        bus.cp0_rsel  = 3'd0;
        #1;
        nvec++; if (bus.cp0_rdata !== 32'd0) begin nerr++; $display("FAIL read_reg3 got %h exp 0", bus.cp0_rdata); end
        // no write bypass: read sees the old EPC while the write is pending
        bus.cp0_raddr = 5'd14;
        bus.cp0_we    = 1'b1;
        bus.cp0_waddr = 5'd14;
        bus.cp0_wdata = 32'h0000_0000;
        #1;
        nvec++; if (bus.cp0_rdata !== 32'h1234_5678) begin nerr++; $display("FAIL read_no_bypass got %h exp %h", bus.cp0_rdata, 32'h1234_5678); end
        tick();
        idle();
        nvec++; if (bus.cp0_rdata !== 32'h0000_0000) begin nerr++; $display("FAIL read_after_write got %h exp 0", bus.cp0_rdata); end
    endtask

    task automatic test_exc_adel();
        bus.excepttype   = EXC_ADEL;
        bus.exc_pc       = 32'hBFC0_1000;
        bus.exc_bd       = 1'b1;
        bus.exc_badvaddr = 32'h8000_0003;
        tick();
        idle();
        nvec++; if (bus.cp0_epc !== 32'hBFC0_0FFC) begin nerr++; $display("FAIL adel_epc got %h exp %h", bus.cp0_epc, 32'hBFC0_0FFC); end
        nvec++; if (bus.cp0_cause !== 32'h8000_0010) begin nerr++; $display("FAIL adel_cause got %h exp %h", bus.cp0_cause, 32'h8000_0010); end
        nvec++; if (bus.cp0_badvaddr !== 32'h8000_0003) begin nerr++; $display("FAIL adel_badvaddr got %h exp %h", bus.cp0_badvaddr, 32'h8000_0003); end
        nvec++; if (bus.cp0_status !== 32'h0040_0002) begin nerr++; $display("FAIL adel_status got %h exp %h", bus.cp0_status, 32'h0040_0002); end
        bus.cp0_raddr = 5'd8;
        #1;
        nvec++; if (bus.cp0_rdata !== 32'h8000_0003) begin nerr++; $display("FAIL adel_rd_badvaddr got %h exp %h", bus.cp0_rdata, 32'h8000_0003); end
    endtask

    task automatic test_exc_nested_eret();
        bus.excepttype   = EXC_SYS;
        bus.exc_pc       = 32'hBFC0_2000;
        bus.exc_bd       = 1'b0;
        bus.exc_badvaddr = 32'h1111_1111;
        tick();
        idle();
        nvec++; if (bus.cp0_epc !== 32'hBFC0_0FFC) begin nerr++; $display("FAIL nested_epc got %h exp %h", bus.cp0_epc, 32'hBFC0_0FFC); end
        nvec++; if (bus.cp0_cause !== 32'h8000_0020) begin nerr++; $display("FAIL nested_cause got %h exp %h", bus.cp0_cause, 32'h8000_0020); end
        nvec++; if (bus.cp0_badvaddr !== 32'h8000_0003) begin nerr++; $display("FAIL nested_badvaddr got %h exp %h", bus.cp0_badvaddr, 32'h8000_0003); end
        bus.excepttype = EXC_ERET;
        bus.exc_pc     = 32'hBFC0_3000;
        tick();
        idle();
        nvec++; if (bus.cp0_status !== 32'h0040_0000) begin nerr++; $display("FAIL eret_status got %h exp %h", bus.cp0_status, 32'h0040_0000); end
        nvec++; if (bus.cp0_epc !== 32'hBFC0_0FFC) begin nerr++; $display("FAIL eret_epc got %h exp %h", bus.cp0_epc, 32'hBFC0_0FFC); end
        nvec++; if (bus.cp0_cause !== 32'h8000_0020) begin nerr++; $display("FAIL eret_cause got %h exp %h", bus.cp0_cause, 32'h8000_0020); end
    endtask

    task automatic test_we_with_int();
        bus.cp0_we     = 1'b1;
        bus.cp0_waddr  = 5'd12;
        bus.cp0_wdata  = 32'h0000_FF01;
        bus.excepttype = EXC_INT;
        bus.exc_pc     = 32'h0000_1234;
        bus.exc_bd     = 1'b0;
        tick();
        idle();
        nvec++; if (bus.cp0_status !== 32'h0040_FF03) begin nerr++; $display("FAIL we_int_status got %h exp %h", bus.cp0_status, 32'h0040_FF03); end
        nvec++; if (bus.cp0_cause !== 32'h0000_0000) begin nerr++; $display("FAIL we_int_cause got %h exp 0", bus.cp0_cause); end
        nvec++; if (bus.cp0_epc !== 32'h0000_1234) begin nerr++; $display("FAIL we_int_epc got %h exp %h", bus.cp0_epc, 32'h0000_1234); end
    endtask

    task automatic test_timer();
`ifdef CP0_TIMER_EN
        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd10);
        for (int i = 0; i < 19; i++) tick();
        nvec++; if (bus.timer_int !== 1'b0) begin nerr++; $display("FAIL timer_early got %b exp 0", bus.timer_int); end
        tick();
        nvec++; if (bus.timer_int !== 1'b1) begin nerr++; $display("FAIL timer_rise got %b exp 1", bus.timer_int); end
        nvec++; if (bus.cp0_cause[30] !== 1'b1) begin nerr++; $display("FAIL timer_cause_ti got %b exp 1", bus.cp0_cause[30]); end
        tick();
        nvec++; if (bus.timer_int !== 1'b1) begin nerr++; $display("FAIL timer_sticky got %b exp 1", bus.timer_int); end
        mtc0(5'd11, 32'd40);
        nvec++; if (bus.timer_int !== 1'b0) begin nerr++; $display("FAIL timer_clear got %b exp 0", bus.timer_int); end
        bus2.cp0_we    = 1'b1;
        bus2.cp0_waddr = 5'd9;
        bus2.cp0_wdata = 32'hFFFF_FFFF;
        tick();
        idle();
        nvec++; if (bus2.cp0_rdata !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL count_load got %h exp %h", bus2.cp0_rdata, 32'hFFFF_FFFF); end
        tick();
        nvec++; if (bus2.cp0_rdata !== 32'd0) begin nerr++; $display("FAIL count_wrap got %h exp 0", bus2.cp0_rdata); end
        bus2.cp0_we    = 1'b1;
        bus2.cp0_waddr = 5'd9;
        bus2.cp0_wdata = 32'd5;
        tick();
        idle();
        nvec++; if (bus2.cp0_rdata !== 32'd5) begin nerr++; $display("FAIL count_override got %h exp 5", bus2.cp0_rdata); end
`else
        mtc0(5'd9, 32'h0000_0077);
        mtc0(5'd11, 32'h0000_0001);
        for (int i = 0; i < 4; i++) tick();
        bus.cp0_raddr = 5'd9;
        #1;
        nvec++; if (bus.cp0_rdata !== 32'd0) begin nerr++; $display("FAIL count_absent got %h exp 0", bus.cp0_rdata); end
        bus.cp0_raddr = 5'd11;
        #1;
        nvec++; if (bus.cp0_rdata !== 32'd0) begin nerr++; $display("FAIL compare_absent got %h exp 0", bus.cp0_rdata); end
        nvec++; if (bus.timer_int !== 1'b0) begin nerr++; $display("FAIL timer_absent got %b exp 0", bus.timer_int); end
`endif
    endtask

    task automatic test_reset_midrun();
        mtc0(5'd12, 32'h0000_FF03);
        mtc0(5'd14, 32'hCAFE_0000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        nvec++; if (bus.cp0_status !== 32'h0040_0000) begin nerr++; $display("FAIL midrst_status got %h exp %h", bus.cp0_status, 32'h0040_0000); end
        nvec++; if (bus.cp0_epc !== 32'd0) begin nerr++; $display("FAIL midrst_epc got %h exp 0", bus.cp0_epc); end
        nvec++; if (bus.cp0_badvaddr !== 32'd0) begin nerr++; $display("FAIL midrst_badvaddr got %h exp 0", bus.cp0_badvaddr); end
        tick();
        rst = 1'b0;
        nvec++; if (bus.cp0_cause !== 32'd0) begin nerr++; $display("FAIL midrst_cause got %h exp 0", bus.cp0_cause); end
        nvec++; if (bus.timer_int !== 1'b0) begin nerr++; $display("FAIL midrst_timer_int got %b exp 0", bus.timer_int); end
        tick();
    endtask

    initial begin
        test_reset();
        test_write_masks();
        test_unmapped();
        test_exc_adel();
        test_exc_nested_eret();
        test_we_with_int();
        test_timer();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
